// File: rtl/wb_arbiter_2m.sv
// -----------------------------------------------------------------------------
// wb_arbiter_2m
//
// Two-master / one-slave Wishbone classic arbiter. Master 0 is the instruction
// port and master 1 the data port. Ownership is granted from IDLE one cycle
// after a request is seen, and is held for as long as the owner keeps cyc high.
// Simultaneous requests from IDLE go to the master that did not own the bus
// most recently. A wait counter aborts a transfer that the slave fails to
// acknowledge within TIMEOUT_CYCLES.
//
// Parameters
//   ADDR_WIDTH      address width of every port
//   DATA_WIDTH      data width; byte-select width is DATA_WIDTH/8
//   TIMEOUT_CYCLES  wait cycles tolerated before an abort (1..65535)
//
// Ports
//   clk_core, rst_core        clock, synchronous active-high reset
//   m0_* / m1_*               master request inputs (cyc/stb/we/sel/addr/data_w)
//                             and response outputs (ack/err/data_r)
//   s_*                       shared slave request outputs, s_ack/s_data_r in
//   grant                     one-hot owner, bit0 = m0, bit1 = m1, 0 when idle
//   timeout_flag              sticky, set by any abort, cleared by reset
// -----------------------------------------------------------------------------
module wb_arbiter_2m #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_core,
    input  logic                      rst_core,

    input  logic                      m0_cyc,
    input  logic                      m0_stb,
    input  logic                      m0_we,
    input  logic [DATA_WIDTH/8-1:0]   m0_sel,
    input  logic [ADDR_WIDTH-1:0]     m0_addr,
    input  logic [DATA_WIDTH-1:0]     m0_data_w,
    output logic                      m0_ack,
    output logic                      m0_err,
    output logic [DATA_WIDTH-1:0]     m0_data_r,

    input  logic                      m1_cyc,
    input  logic                      m1_stb,
    input  logic                      m1_we,
    input  logic [DATA_WIDTH/8-1:0]   m1_sel,
    input  logic [ADDR_WIDTH-1:0]     m1_addr,
    input  logic [DATA_WIDTH-1:0]     m1_data_w,
    output logic                      m1_ack,
    output logic                      m1_err,
    output logic [DATA_WIDTH-1:0]     m1_data_r,

    output logic                      s_cyc,
    output logic                      s_stb,
    output logic                      s_we,
    output logic [DATA_WIDTH/8-1:0]   s_sel,
    output logic [ADDR_WIDTH-1:0]     s_addr,
    output logic [DATA_WIDTH-1:0]     s_data_w,
    input  logic [DATA_WIDTH-1:0]     s_data_r,
    input  logic                      s_ack,

    output logic [1:0]                grant,
    output logic                      timeout_flag
);

    localparam int unsigned         CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    state_e                 state_q, state_d;
    logic                   last_owner_q, last_owner_d;   // 0 = m0, 1 = m1
    logic [CNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
    logic                   timeout_flag_q, timeout_flag_d;

    logic                   own_cyc;
    logic                   own_stb;
    logic                   abort;

    // -------------------------------------------------------------------------
    // Current owner's handshake, used by both the counter and the slave mux.
    // -------------------------------------------------------------------------
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        case (state_q)
            OWN0: begin
                own_cyc = m0_cyc;
                own_stb = m0_stb;
            end
            OWN1: begin
                own_cyc = m1_cyc;
                own_stb = m1_stb;
            end
            default: begin
                own_cyc = 1'b0;
                own_stb = 1'b0;
            end
        endcase
    end

    // An ack arriving in the limit cycle wins over the abort.
    assign abort = (state_q != IDLE) && own_cyc && own_stb && !s_ack &&
                   (wait_cnt_q == CNT_MAX);

    // -------------------------------------------------------------------------
    // Next-state, ownership history, wait counter and sticky flag.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        last_owner_d   = last_owner_q;
        timeout_flag_d = timeout_flag_q;
        wait_cnt_d     = '0;

        case (state_q)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_d = last_owner_q ? OWN0 : OWN1;
                end else if (m0_cyc) begin
                    state_d = OWN0;
                end else if (m1_cyc) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                last_owner_d = 1'b0;
                if (abort) begin
                    state_d = IDLE;
                end else if (!m0_cyc) begin
                    // Hand straight over to a waiting master, no idle bubble.
                    state_d = m1_cyc ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                last_owner_d = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (!m1_cyc) begin
                    state_d = m0_cyc ? OWN0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            timeout_flag_d = 1'b1;
        end

        // Counts only while the same owner keeps strobing without an ack;
        // any ack, strobe gap or ownership change restarts it from zero.
        if ((state_q != IDLE) && (state_d == state_q) && own_stb && !s_ack) begin
            if (wait_cnt_q == CNT_MAX) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state_q        <= IDLE;
            last_owner_q   <= 1'b1;
            wait_cnt_q     <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_owner_q   <= last_owner_d;
            wait_cnt_q     <= wait_cnt_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    // -------------------------------------------------------------------------
    // Slave-side request mux: pass-through of the owner, forced idle on abort.
    // -------------------------------------------------------------------------
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_sel    = '0;
        s_addr   = '0;
        s_data_w = '0;
        case (state_q)
            OWN0: begin
                s_cyc    = m0_cyc && !abort;
                s_stb    = m0_stb && !abort;
                s_we     = m0_we;
                s_sel    = m0_sel;
                s_addr   = m0_addr;
                s_data_w = m0_data_w;
            end
            OWN1: begin
                s_cyc    = m1_cyc && !abort;
                s_stb    = m1_stb && !abort;
                s_we     = m1_we;
                s_sel    = m1_sel;
                s_addr   = m1_addr;
                s_data_w = m1_data_w;
            end
            default: begin
                s_cyc    = 1'b0;
                s_stb    = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Master responses. A cycle with reset asserted abandons the transfer, so
    // neither ack nor err may escape during it.
    // -------------------------------------------------------------------------
    always_comb begin
        m0_ack = (state_q == OWN0) && s_ack && m0_stb && !rst_core;
        m1_ack = (state_q == OWN1) && s_ack && m1_stb && !rst_core;
        m0_err = (state_q == OWN0) && abort && !rst_core;
        m1_err = (state_q == OWN1) && abort && !rst_core;
    end

    assign m0_data_r    = s_data_r;
    assign m1_data_r    = s_data_r;
    assign grant        = {state_q == OWN1, state_q == OWN0};
    assign timeout_flag = timeout_flag_q;

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width; select width is DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 1..65535, max wait cycles for slave ack before abort.
REQ-004 clk_core  input  1  core clock; all state updates on rising edge.
REQ-005 rst_core  input  1  reset, synchronous, active-high.
REQ-006 m0_cyc, m0_stb, m0_we  input  1 each  master 0 (instruction) Wishbone classic controls.
REQ-007 m0_sel  input  DATA_WIDTH/8; m0_addr  input  ADDR_WIDTH; m0_data_w  input  DATA_WIDTH  master 0 request payload.
REQ-008 m0_ack, m0_err  output  1 each; m0_data_r  output  DATA_WIDTH  master 0 response.
REQ-009 m1_* ports: identical set for master 1 (data).
REQ-010 s_cyc, s_stb, s_we  output  1 each; s_sel  output  DATA_WIDTH/8; s_addr  output  ADDR_WIDTH; s_data_w  output  DATA_WIDTH  shared slave port.
REQ-011 s_data_r  input  DATA_WIDTH; s_ack  input  1  slave response.
REQ-012 grant  output  2  one-hot current owner (bit0 = m0, bit1 = m1), 2'b00 when idle.
REQ-013 timeout_flag  output  1  sticky, set on any abort.

Function
REQ-014 States: IDLE, OWN0, OWN1; grant SHALL be 2'b01 in OWN0, 2'b10 in OWN1, 2'b00 in IDLE.
REQ-015 Register last_owner SHALL record the master most recently granted.
REQ-016 IDLE: only m0_cyc -> OWN0; only m1_cyc -> OWN1; both -> master != last_owner; neither -> IDLE.
REQ-017 Arbitration latency SHALL be exactly 1 cycle: request sampled in IDLE, slave sees it on the next cycle.
REQ-018 OWNx: s_cyc/s_stb/s_we/s_sel/s_addr/s_data_w SHALL combinationally equal master x's signals.
REQ-019 IDLE: all s_* outputs SHALL be 0.
REQ-020 mx_ack SHALL equal s_ack && mx_stb in OWNx, else 0; non-owner ack and err SHALL always be 0.
REQ-021 m0_data_r and m1_data_r SHALL both equal s_data_r at all times.
REQ-022 Ownership SHALL be held while owner's cyc is 1 (multi-beat cycles uninterrupted).
REQ-023 OWNx with mx_cyc = 0: if other master's cyc = 1, next state is the other OWN state (no idle bubble), else IDLE; last_owner <= x.
REQ-024 Wait counter, width ceil(log2(TIMEOUT_CYCLES+1)) bits: increments each OWN cycle with s_stb = 1 and s_ack = 0; clears on s_ack, on state change, and when s_stb = 0.
REQ-025 Abort: when counter == TIMEOUT_CYCLES and s_ack = 0, that cycle SHALL drive mx_err = 1, force s_cyc = s_stb = 0, and set timeout_flag; next state is IDLE, last_owner <= x.
REQ-026 An s_ack in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: normal ack, no err, no flag.
REQ-027 After an abort, the aborted master SHALL be re-arbitrated normally if its cyc stays high.
REQ-028 Counter SHALL never wrap; it saturates at TIMEOUT_CYCLES.

Reset
REQ-029 rst_core = 1 at a clock edge SHALL force IDLE, last_owner = 1 (m0 wins first tie), counter = 0, timeout_flag = 0.
REQ-030 After reset all outputs SHALL be 0; reset mid-transaction SHALL abandon it with no ack or err to either master.

Verification
REQ-031 After reset, m0 and m1 raise cyc/stb in the same cycle -> grant = 01 next cycle, s_addr = m0_addr; after m0 drops cyc, grant = 10 on the following cycle.
REQ-032 m1 alone, read addr 0x0000_0040, slave acks with 0xDEAD_BEEF after 3 cycles -> m1_ack = 1 for 1 cycle, m1_data_r = 0xDEAD_BEEF, m0_ack = 0.
REQ-033 m0 holds cyc over 4 beats while m1 requests -> grant stays 01 for all 4 acks; m1 is granted in the cycle after m0 cyc falls.
REQ-034 TIMEOUT_CYCLES = 4, slave never acks m0 -> m0_err = 1 exactly once, s_cyc = 0 in that cycle, timeout_flag = 1, next state IDLE.
REQ-035 TIMEOUT_CYCLES = 4, s_ack arrives in the same cycle the counter hits 4 -> m0_ack = 1, m0_err = 0, timeout_flag = 0.
REQ-036 rst_core pulsed during an m1 wait -> next cycle grant = 00, all s_* = 0, timeout_flag = 0, no m1_ack or m1_err.
